// File: rtl/stopwatch_pkg.sv
// Shared field widths, limits and the packed time word for the stopwatch family.
package stopwatch_pkg;

    localparam int unsigned H_W    = 5;
    localparam int unsigned M_W    = 6;
    localparam int unsigned S_W    = 6;
    localparam int unsigned CS_W   = 7;
    localparam int unsigned TIME_W = H_W + M_W + S_W + CS_W;

    localparam int unsigned CS_MAX = 99;
    localparam int unsigned S_MAX  = 59;
    localparam int unsigned M_MAX  = 59;

    typedef struct packed {
        logic [H_W-1:0]  h;
        logic [M_W-1:0]  m;
        logic [S_W-1:0]  s;
        logic [CS_W-1:0] cs;
    } time_t;

    function automatic logic [TIME_W-1:0] pack_time(input time_t t);
        return TIME_W'(t);
    endfunction

    function automatic time_t unpack_time(input logic [TIME_W-1:0] w);
        return time_t'(w);
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Synchronous show-ahead FIFO; a push is accepted when full only if a pop frees a slot.
module lap_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_next;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = rd & valid;
    assign do_push = wr & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            valid <= (count_next != '0);
            full  <= (count_next == CW'(DEPTH));
        end
    end

    // Storage needs no reset: valid gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/stopwatch_lap.sv
// Up/down h:m:s:cs stopwatch with tick prescaler, edge-detected controls and lap FIFO.
module stopwatch_lap
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 100_000_000,
    parameter int unsigned TICK_HZ   = 100,
    parameter int unsigned HOUR_MAX  = 24,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_stop,
    input  logic              lap,
    input  logic              clear,
    input  logic              dir,
    input  logic [TIME_W-1:0] preset,
    output logic [TIME_W-1:0] disp_time,
    output logic              running,
    output logic              done,
    output logic [TIME_W-1:0] lap_data,
    output logic              lap_valid,
    input  logic              lap_rd,
    output logic              lap_full,
    output logic              lap_drop
);

    localparam int unsigned DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);

    time_t         tm;
    time_t         t_up;
    time_t         t_dn;
    logic [PW-1:0] presc;
    logic          ss_q;
    logic          lap_q;
    logic          armed;
    logic          start_edge;
    logic          lap_edge;
    logic          tick;
    logic          is_zero;
    logic          hit_zero;

    function automatic time_t clamp_time(input time_t t);
        time_t r;
        r = t;
        if (t.h  > H_W'(HOUR_MAX - 1)) r.h  = H_W'(HOUR_MAX - 1);
        if (t.m  > M_W'(M_MAX))        r.m  = M_W'(M_MAX);
        if (t.s  > S_W'(S_MAX))        r.s  = S_W'(S_MAX);
        if (t.cs > CS_W'(CS_MAX))      r.cs = CS_W'(CS_MAX);
        return r;
    endfunction

    // armed masks edges on the first cycle after reset so a held level is not seen as a press
    assign start_edge = armed & start_stop & ~ss_q;
    assign lap_edge   = armed & lap & ~lap_q;
    assign tick       = running & (presc == PW'(DIV - 1));
    assign is_zero    = (tm == '0);
    assign hit_zero   = tick & dir & (is_zero | (t_dn == '0));
    assign disp_time  = pack_time(tm);

    // Increment cascade
    always_comb begin
        t_up = tm;
        if (tm.cs >= CS_W'(CS_MAX)) begin
            t_up.cs = '0;
            if (tm.s >= S_W'(S_MAX)) begin
                t_up.s = '0;
                if (tm.m >= M_W'(M_MAX)) begin
                    t_up.m = '0;
                    t_up.h = (tm.h >= H_W'(HOUR_MAX - 1)) ? '0 : tm.h + H_W'(1);
                end else begin
                    t_up.m = tm.m + M_W'(1);
                end
            end else begin
                t_up.s = tm.s + S_W'(1);
            end
        end else begin
            t_up.cs = tm.cs + CS_W'(1);
        end
    end

    // Decrement cascade
    always_comb begin
        t_dn = tm;
        if (tm.cs != '0) begin
            t_dn.cs = tm.cs - CS_W'(1);
        end else begin
            t_dn.cs = CS_W'(CS_MAX);
            if (tm.s != '0) begin
                t_dn.s = tm.s - S_W'(1);
            end else begin
                t_dn.s = S_W'(S_MAX);
                if (tm.m != '0) begin
                    t_dn.m = tm.m - M_W'(1);
                end else begin
                    t_dn.m = M_W'(M_MAX);
                    t_dn.h = (tm.h != '0) ? tm.h - H_W'(1) : H_W'(HOUR_MAX - 1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tm       <= '0;
            presc    <= '0;
            ss_q     <= 1'b0;
            lap_q    <= 1'b0;
            armed    <= 1'b0;
            running  <= 1'b0;
            done     <= 1'b0;
            lap_drop <= 1'b0;
        end else begin
            ss_q  <= start_stop;
            lap_q <= lap;
            armed <= 1'b1;
            done  <= 1'b0;
            if (clear) begin
                tm       <= clamp_time(unpack_time(preset));
                presc    <= '0;
                running  <= 1'b0;
                lap_drop <= 1'b0;
            end else begin
                if (lap_edge & lap_full & ~lap_rd) lap_drop <= 1'b1;
                presc <= (!running || tick) ? '0 : presc + PW'(1);
                if (tick) begin
                    if (!dir)         tm <= t_up;
                    else if (!is_zero) tm <= t_dn;
                end
                // A down-count landing on zero stops and pulses done together
                if (hit_zero) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end else if (start_edge && !(dir && is_zero)) begin
                    running <= ~running;
                end
            end
        end
    end

    lap_fifo #(
        .WIDTH (TIME_W),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (lap_edge),
        .wdata (pack_time(tm)),
        .rd    (lap_rd),
        .rdata (lap_data),
        .valid (lap_valid),
        .full  (lap_full)
    );

endmodule

// File: tb/tb_stopwatch_lap.sv
// Directed bench for stopwatch_lap at CLK_HZ=1000, TICK_HZ=100 (DIV=10), HOUR_MAX=2.
module tb_stopwatch_lap;

    localparam int unsigned CLK_HZ    = 1000;
    localparam int unsigned TICK_HZ   = 100;
    localparam int unsigned HOUR_MAX  = 2;
    localparam int unsigned LAP_DEPTH = 4;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        start_stop = 1'b0;
    logic        lap        = 1'b0;
    logic        clear      = 1'b0;
    logic        dir        = 1'b0;
    logic        lap_rd     = 1'b0;
    logic [23:0] preset     = '0;
    logic [23:0] disp_time;
    logic [23:0] lap_data;
    logic        running;
    logic        done;
    logic        lap_valid;
    logic        lap_full;
    logic        lap_drop;

    int n_tests = 0;
    int n_fail  = 0;

    stopwatch_lap #(
        .CLK_HZ    (CLK_HZ),
        .TICK_HZ   (TICK_HZ),
        .HOUR_MAX  (HOUR_MAX),
        .LAP_DEPTH (LAP_DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .dir        (dir),
        .preset     (preset),
        .disp_time  (disp_time),
        .running    (running),
        .done       (done),
        .lap_data   (lap_data),
        .lap_valid  (lap_valid),
        .lap_rd     (lap_rd),
        .lap_full   (lap_full),
        .lap_drop   (lap_drop)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] tw(input int h, input int m, input int s, input int cs);
        return {5'(h), 6'(m), 6'(s), 7'(cs)};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Edge lands on the posedge between the two negedges
    task automatic pulse_start();
        @(negedge clk) start_stop = 1'b1;
        @(negedge clk) start_stop = 1'b0;
    endtask

    task automatic pulse_lap(input int d);
        repeat (d) @(negedge clk);
        lap = 1'b1;
        @(negedge clk) lap = 1'b0;
    endtask

    task automatic do_clear(input logic [23:0] p, input logic d);
        @(negedge clk);
        preset = p;
        dir    = d;
        clear  = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [23:0] exp);
        check(tag, 32'(lap_data), 32'(exp));
        lap_rd = 1'b1;
        @(negedge clk) lap_rd = 1'b0;
    endtask

    initial begin
        #1_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

    initial begin
        int          done_at;
        int          n_done;
        logic        prev_run;
        logic        run_before;
        logic        run_at;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_disp", 32'(disp_time), 32'(0));
        check("rst_running", 32'(running), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_valid", 32'(lap_valid), 32'(0));
        check("rst_full", 32'(lap_full), 32'(0));
        check("rst_drop", 32'(lap_drop), 32'(0));
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1000 clk up from zero, then stop and hold
        pulse_start();
        repeat (1000) @(posedge clk);
        #1;
        check("run1000_disp", 32'(disp_time), 32'(tw(0, 0, 1, 0)));
        check("run1000_running", 32'(running), 32'(1));
        pulse_start();
        check("stop_running", 32'(running), 32'(0));
        repeat (500) @(posedge clk);
        #1;
        check("stop_frozen", 32'(disp_time), 32'(tw(0, 0, 1, 0)));

        // Wrap through HOUR_MAX
        do_clear(tw(1, 59, 59, 98), 1'b0);
        check("clear_load", 32'(disp_time), 32'(tw(1, 59, 59, 98)));
        pulse_start();
        repeat (30) @(posedge clk);
        #1;
        check("wrap_disp", 32'(disp_time), 32'(tw(0, 0, 0, 1)));
        check("wrap_running", 32'(running), 32'(1));

        // Down-count to zero
        do_clear(tw(0, 0, 0, 2), 1'b1);
        pulse_start();
        done_at  = -1;
        n_done   = 0;
        prev_run = running;
        run_before = 1'b0;
        run_at     = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_done++;
                if (done_at < 0) begin
                    done_at    = i;
                    run_before = prev_run;
                    run_at     = running;
                end
            end
            prev_run = running;
        end
        check("down_done_cycle", 32'(done_at), 32'(20));
        check("down_done_count", 32'(n_done), 32'(1));
        check("down_run_before", 32'(run_before), 32'(1));
        check("down_run_at", 32'(run_at), 32'(0));
        check("down_disp", 32'(disp_time), 32'(0));
        pulse_start();
        repeat (3) @(negedge clk);
        check("zero_start_ignored", 32'(running), 32'(0));

        // Overfill lap FIFO
        do_clear(tw(0, 0, 0, 0), 1'b0);
        pulse_start();
        pulse_lap(19);
        pulse_lap(19);
        pulse_lap(19);
        pulse_lap(19);
        pulse_lap(19);
        check("ovf_full", 32'(lap_full), 32'(1));
        check("ovf_drop", 32'(lap_drop), 32'(1));
        pop_check("ovf_pop0", tw(0, 0, 0, 1));
        pop_check("ovf_pop1", tw(0, 0, 0, 3));
        pop_check("ovf_pop2", tw(0, 0, 0, 5));
        pop_check("ovf_pop3", tw(0, 0, 0, 7));
        check("ovf_empty", 32'(lap_valid), 32'(0));

        // Clear keeps FIFO contents; simultaneous push/pop when full
        do_clear(tw(0, 0, 0, 0), 1'b0);
        check("clr_drop", 32'(lap_drop), 32'(0));
        pulse_start();
        pulse_lap(19);
        pulse_lap(19);
        pulse_lap(19);
        pulse_lap(19);
        do_clear(tw(0, 0, 0, 0), 1'b0);
        check("keep_full", 32'(lap_full), 32'(1));
        check("keep_head", 32'(lap_data), 32'(tw(0, 0, 0, 1)));
        check("keep_running", 32'(running), 32'(0));
        check("keep_disp", 32'(disp_time), 32'(0));
        @(negedge clk);
        lap    = 1'b1;
        lap_rd = 1'b1;
        @(negedge clk);
        lap    = 1'b0;
        lap_rd = 1'b0;
        check("rw_full", 32'(lap_full), 32'(1));
        check("rw_drop", 32'(lap_drop), 32'(0));
        pop_check("rw_pop0", tw(0, 0, 0, 3));
        pop_check("rw_pop1", tw(0, 0, 0, 5));
        pop_check("rw_pop2", tw(0, 0, 0, 7));
        pop_check("rw_pop3", tw(0, 0, 0, 0));
        check("rw_empty", 32'(lap_valid), 32'(0));

        // Clamp on load, then clear beats a start edge
        do_clear(tw(31, 63, 63, 127), 1'b0);
        check("clamp", 32'(disp_time), 32'(tw(1, 59, 59, 99)));
        @(negedge clk);
        preset     = tw(0, 1, 2, 3);
        clear      = 1'b1;
        start_stop = 1'b1;
        @(negedge clk);
        clear      = 1'b0;
        start_stop = 1'b0;
        check("clr_start_running", 32'(running), 32'(0));
        check("clr_start_disp", 32'(disp_time), 32'(tw(0, 1, 2, 3)));
        @(negedge clk);
        check("clr_start_after", 32'(running), 32'(0));

        // Reset mid-run with start_stop and lap held high
        pulse_start();
        repeat (15) @(negedge clk);
        check("pre_rst_running", 32'(running), 32'(1));
        reset      = 1'b1;
        start_stop = 1'b1;
        lap        = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_disp", 32'(disp_time), 32'(0));
        check("mid_rst_running", 32'(running), 32'(0));
        check("mid_rst_valid", 32'(lap_valid), 32'(0));
        check("mid_rst_drop", 32'(lap_drop), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_running", 32'(running), 32'(0));
        check("post_rst_valid", 32'(lap_valid), 32'(0));
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        pulse_start();
        check("post_rst_start", 32'(running), 32'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_lap.md
Name: stopwatch_lap

Overview:
- Parametrised successor to the team's h:m:s:cs stopwatch: counts up or down from a loadable preset with a built-in tick prescaler.
- Provides edge-detected start/stop, a lap-capture FIFO with read handshake, and a terminal-count flag.
- Sits between debounced board buttons and the display/UART formatter; output packing matches the existing 24-bit {h,m,s,cs} display word.

Parameters:
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, count rate of the lowest field; CLK_HZ/TICK_HZ must be an integer ≥ 2.
- HOUR_MAX, 24, hour field wraps/terminates at this value (≤ 31).
- LAP_DEPTH, 4, lap FIFO entries (power of two, 2..16).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start_stop  in  1  level from debouncer; each rising edge toggles run state.
- lap  in  1  level; each rising edge captures the current time into the lap FIFO.
- clear  in  1  level; while high, time := preset, run := 0.
- dir  in  1  0 = count up, 1 = count down; sampled at the tick.
- preset  in  24  {h[4:0],m[5:0],s[5:0],cs[6:0]} load value for clear.
- disp_time  out  24  current time, same packing as preset.
- running  out  1  run state.
- done  out  1  one-cycle pulse when a down-count reaches 0:00:00.00.
- lap_data  out  24  FIFO head (show-ahead).
- lap_valid  out  1  FIFO not empty.
- lap_rd  in  1  pops head when lap_valid & lap_rd.
- lap_full  out  1  FIFO full.
- lap_drop  out  1  sticky; set when a lap is captured while full; cleared by reset or clear.

Behaviour:
- Reset: disp_time = 0, running = 0, done = 0, FIFO empty, lap_valid = 0, lap_full = 0, lap_drop = 0, prescaler = 0, edge-detect registers = 0. Reset has priority over every other input.
- Edge detect: register start_stop and lap; pulse = in & ~in_q. The input level present at reset does not generate an edge on the first post-reset cycle.
- Prescaler: counts 0..CLK_HZ/TICK_HZ-1 only while running; tick = 1 for one cycle at terminal count. Prescaler is zeroed when stopped or on clear, so the first tick after start arrives exactly DIV cycles later.
- Count up (on tick):
  - cs 0..99; wrap carries to s 0..59, then m 0..59, then h 0..HOUR_MAX-1.
  - At HOUR_MAX-1:59:59.99 it wraps to 0 and keeps running.
- Count down (on tick):
  - Each field borrows; cs 0 → 99 with borrow, etc.
  - At 0:00:00.00 with dir = 1 the count holds, running → 0, and done pulses in the same cycle running falls.
  - A start edge while the count is 0 and dir = 1 is ignored.
- Field updates use compare-to-limit only (no out-of-range states). An out-of-range preset field is clamped to its limit on load.
- clear (level) beats start_stop and tick in the same cycle; a lap edge in a clear cycle captures the pre-clear value.
- disp_time is registered and updates on the cycle after the tick (latency 1 clk from tick).
- Lap FIFO:
  - Capture writes the current registered disp_time.
  - Write and pop in the same cycle is allowed: when full, the write succeeds because an entry is freed; when empty, the write proceeds and the pop is ignored.
  - When full with no pop, the write is dropped and lap_drop is set.
  - FIFO contents survive clear; only reset empties it.
- dir may change at any time; the change takes effect at the next tick, with no glitch on disp_time.

Decomposition:
- Package stopwatch_pkg: field widths (H_W = 5, M_W = 6, S_W = 6, CS_W = 7), limits (CS_MAX = 99, S_MAX = 59, M_MAX = 59), and a time_t packed struct plus pack/unpack functions.
- Sub-module lap_fifo (sync, show-ahead, parametrised WIDTH/DEPTH, full/valid/rd/wr ports). It is reusable by the alarm block.
- Prescaler, edge detect and digit cascade stay in the top module.

Test Plan:
- Test params: CLK_HZ = 1000, TICK_HZ = 100 (DIV = 10), HOUR_MAX = 2.
- Reset, start edge, run 1000 clk → disp_time = {0,0,1,0}, running = 1; stop edge → value frozen for 500 clk.
- Preset {1,59,59,98}, clear, start, 30 clk up → 0:00:00.01 after wrapping through HOUR_MAX; running stays 1.
- dir = 1, preset {0,0,0,2}, clear, start → done pulses exactly once on the cycle running falls, at 20 clk; disp_time = 0. A further start edge → running stays 0.
- 5 lap edges while running with no rd (LAP_DEPTH = 4) → lap_full = 1, lap_drop = 1. Popping 4 returns ascending times in capture order, then lap_valid = 0.
- Simultaneous lap edge and lap_rd with FIFO full → occupancy stays 4 and lap_drop is not set. Simultaneous clear and start edge → running = 0, disp_time = preset.
- Reset asserted mid-run with start_stop held high → all outputs at reset values. After release, no spurious toggle; running stays 0.
